// File: rtl/lcd_pkg.sv
// Shared constants and state encoding for the LCD clock text formatter.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;

  localparam logic [7:0] ASCII_ZERO   = 8'h30;
  localparam logic [7:0] ASCII_COLON  = 8'h3A;
  localparam logic [7:0] ASCII_SPACE  = 8'h20;
  localparam logic [7:0] ASCII_QMARK  = 8'h3F;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    CLR_WAIT,
    IDLE,
    ADDR,
    TEXT
  } lcd_state_e;

endpackage

// File: rtl/bcd_digit_ascii.sv
// One BCD nibble to its ASCII digit; nibbles above 9 render as '?'.
module bcd_digit_ascii
  import lcd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASCII_QMARK;
    if (bcd <= 4'd9) ascii = ASCII_ZERO + {4'd0, bcd};
  end

endmodule

// File: rtl/lcd_clock_formatter.sv
// HD44780 init sequencer plus "HH:MM:SS" line-1 text streamer over valid/ready.
// Optional build macro LCD_BLINK_COLON_EN: colons become spaces on odd seconds.
module lcd_clock_formatter
  import lcd_pkg::*;
#(
  parameter int          INIT_WAIT_CYCLES  = 600000,
  parameter int          CLEAR_WAIT_CYCLES = 40000,
  parameter logic [7:0]  LINE1_ADDR        = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       time_valid,
  input  logic [7:0] hh_bcd,
  input  logic [7:0] mm_bcd,
  input  logic [7:0] ss_bcd,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_rs,
  output logic [7:0] out_data,
  output logic       busy
);

  // Handshake: a byte moves when out_valid && out_ready at posedge clk; while
  // stalled, out_rs/out_data hold, and out_valid only drops after a transfer
  // or on reset. Outputs decode from registered state, so they never glitch.

  localparam int WAIT_MAX = (INIT_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ?
                            INIT_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYCLES - 1);

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       work_hh_q, work_hh_d, work_mm_q, work_mm_d, work_ss_q, work_ss_d;
  logic [7:0]       pend_hh_q, pend_hh_d, pend_mm_q, pend_mm_d, pend_ss_q, pend_ss_d;
  logic             pend_q, pend_d;

  logic       xfer;
  logic [3:0] nibble;
  logic [7:0] digit_ascii;
  logic [7:0] colon_char;
  logic [7:0] text_char;

  assign xfer = out_valid && out_ready;
  assign busy = (state_q != IDLE);

  always_comb begin
    nibble = 4'h0;
    case (idx_q)
      3'd0:    nibble = work_hh_q[7:4];
      3'd1:    nibble = work_hh_q[3:0];
      3'd3:    nibble = work_mm_q[7:4];
      3'd4:    nibble = work_mm_q[3:0];
      3'd6:    nibble = work_ss_q[7:4];
      3'd7:    nibble = work_ss_q[3:0];
      default: nibble = 4'h0;
    endcase
  end

  bcd_digit_ascii u_digit (
    .bcd   (nibble),
    .ascii (digit_ascii)
  );

`ifdef LCD_BLINK_COLON_EN
  assign colon_char = work_ss_q[0] ? ASCII_SPACE : ASCII_COLON;
`else
  assign colon_char = ASCII_COLON;
`endif

  assign text_char = (idx_q == 3'd2 || idx_q == 3'd5) ? colon_char : digit_ascii;

  always_comb begin
    out_valid = 1'b0;
    out_rs    = 1'b0;
    out_data  = 8'h00;
    case (state_q)
      INIT: begin
        out_valid = 1'b1;
        case (idx_q[1:0])
          2'd0:    out_data = LCD_FUNC_SET;
          2'd1:    out_data = LCD_DISP_ON;
          2'd2:    out_data = LCD_ENTRY;
          default: out_data = LCD_CLEAR;
        endcase
      end
      ADDR: begin
        out_valid = 1'b1;
        out_data  = LINE1_ADDR;
      end
      TEXT: begin
        out_valid = 1'b1;
        out_rs    = 1'b1;
        out_data  = text_char;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    idx_d     = idx_q;
    work_hh_d = work_hh_q;
    work_mm_d = work_mm_q;
    work_ss_d = work_ss_q;
    pend_hh_d = pend_hh_q;
    pend_mm_d = pend_mm_q;
    pend_ss_d = pend_ss_q;
    pend_d    = pend_q;
    case (state_q)
      PWR_WAIT: begin
        if (wait_q == INIT_LAST) begin
          state_d = INIT;
          wait_d  = '0;
          idx_d   = 3'd0;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      INIT: begin
        if (xfer) begin
          if (idx_q[1:0] == 2'd3) begin
            state_d = CLR_WAIT;
            wait_d  = '0;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      CLR_WAIT: begin
        if (wait_q == CLEAR_LAST) begin
          wait_d = '0;
          if (pend_q) begin
            state_d   = ADDR;
            work_hh_d = pend_hh_q;
            work_mm_d = pend_mm_q;
            work_ss_d = pend_ss_q;
            pend_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      IDLE: begin
        if (time_valid) begin
          state_d   = ADDR;
          work_hh_d = hh_bcd;
          work_mm_d = mm_bcd;
          work_ss_d = ss_bcd;
        end
      end
      ADDR: begin
        if (xfer) begin
          state_d = TEXT;
          idx_d   = 3'd0;
        end
      end
      TEXT: begin
        if (xfer) begin
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
            if (pend_q) begin
              state_d   = ADDR;
              work_hh_d = pend_hh_q;
              work_mm_d = pend_mm_q;
              work_ss_d = pend_ss_q;
              pend_d    = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = PWR_WAIT;
    endcase
    // Applied after the FSM so a strobe coinciding with a pending handoff
    // is kept for the following refresh.
    if (time_valid && state_q != IDLE) begin
      pend_hh_d = hh_bcd;
      pend_mm_d = mm_bcd;
      pend_ss_d = ss_bcd;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= PWR_WAIT;
      wait_q    <= '0;
      idx_q     <= 3'd0;
      work_hh_q <= 8'h00;
      work_mm_q <= 8'h00;
      work_ss_q <= 8'h00;
      pend_hh_q <= 8'h00;
      pend_mm_q <= 8'h00;
      pend_ss_q <= 8'h00;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      idx_q     <= idx_d;
      work_hh_q <= work_hh_d;
      work_mm_q <= work_mm_d;
      work_ss_q <= work_ss_d;
      pend_hh_q <= pend_hh_d;
      pend_mm_q <= pend_mm_d;
      pend_ss_q <= pend_ss_d;
      pend_q    <= pend_d;
    end
  end

endmodule

// File: tb/tb_lcd_clock_formatter.sv
// Scoreboard bench for lcd_clock_formatter with shortened wait parameters.
module tb_lcd_clock_formatter;

  localparam int INIT_W = 20;
  localparam int CLR_W  = 10;
`ifdef LCD_BLINK_COLON_EN
  localparam logic [7:0] COL_ODD = 8'h20;
`else
  localparam logic [7:0] COL_ODD = 8'h3A;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       time_valid = 1'b0;
  logic [7:0] hh_bcd = 8'h00;
  logic [7:0] mm_bcd = 8'h00;
  logic [7:0] ss_bcd = 8'h00;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic       out_rs;
  logic [7:0] out_data;
  logic       busy;

  always #5 clk = ~clk;

  lcd_clock_formatter #(
    .INIT_WAIT_CYCLES  (INIT_W),
    .CLEAR_WAIT_CYCLES (CLR_W),
    .LINE1_ADDR        (8'h80)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .time_valid (time_valid),
    .hh_bcd     (hh_bcd),
    .mm_bcd     (mm_bcd),
    .ss_bcd     (ss_bcd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rs     (out_rs),
    .out_data   (out_data),
    .busy       (busy)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [8:0] exp_q[$];
  logic       stalled = 1'b0;
  logic [8:0] held = 9'h000;
  logic [8:0] mon_e;
  int         cnt;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h001);
  endtask

  task automatic push_line(input logic [63:0] chars);
    exp_q.push_back(9'h080);
    for (int i = 7; i >= 0; i--) exp_q.push_back({1'b1, chars[i*8 +: 8]});
  endtask

  task automatic strobe(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    hh_bcd     = h;
    mm_bcd     = m;
    ss_bcd     = s;
    time_valid = 1'b1;
    tick();
    time_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    int hold = 0;
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      if (rnd) begin
        if (hold > 0) begin
          out_ready = 1'b0;
          hold--;
        end else begin
          out_ready = 1'b1;
          hold = $urandom_range(0, 5);
        end
      end
      tick();
      n++;
    end
    out_ready = 1'b1;
    chk("idle_reached", {31'd0, busy}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  // Monitor: pops on every accepted byte and checks stability across stalls.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled)
          chk("stall_hold", {22'd0, out_valid, out_rs, out_data}, {22'd0, 1'b1, held});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_xfer: got %0h expected none", {out_rs, out_data});
          end else begin
            mon_e = exp_q.pop_front();
            chk("xfer", {23'd0, out_rs, out_data}, {23'd0, mon_e});
          end
          stalled = 1'b0;
        end else if (out_valid) begin
          stalled = 1'b1;
          held    = {out_rs, out_data};
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy",  {31'd0, busy},      32'd1);
    chk("reset_rs",    {31'd0, out_rs},    32'd0);
    chk("reset_data",  {24'd0, out_data},  32'd0);

    // Power-on wait, with a snapshot strobed while still waiting.
    push_init();
    push_line(64'h3132_3A33_343A_3536);
    hh_bcd = 8'h12;
    mm_bcd = 8'h34;
    ss_bcd = 8'h56;
    rst = 1'b1;
    cnt = 0;
    while (!out_valid && cnt < 200) begin
      time_valid = (cnt == 3);
      tick();
      cnt++;
    end
    time_valid = 1'b0;
    chk("pwr_wait_cycles", cnt, INIT_W);

    cnt = 0;
    while (!(out_valid && out_data == 8'h01) && cnt < 50) begin
      tick();
      cnt++;
    end
    chk("clear_offered", {24'd0, out_data}, 32'h01);
    tick();
    cnt = 0;
    while (!out_valid && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("clear_wait_cycles", cnt, CLR_W);
    chk("addr_after_pending", {24'd0, out_data}, 32'h80);
    wait_idle(200, 1'b0);

    // Strobe from IDLE: ADDR offered on the very next cycle.
    push_line(64'h3132_3A33_343A_3536);
    strobe(8'h12, 8'h34, 8'h56);
    chk("idle_latency_valid", {31'd0, out_valid}, 32'd1);
    chk("idle_latency_addr", {24'd0, out_data}, 32'h80);
    wait_idle(200, 1'b0);

    // Same line under random writer stalls.
    push_line(64'h3132_3A33_343A_3536);
    strobe(8'h12, 8'h34, 8'h56);
    wait_idle(400, 1'b1);

    // Two mid-line strobes: only the latest produces a refresh.
    push_line(64'h3132_3A33_343A_3536);
    push_line(64'h3132_3A33_343A_3538);
    strobe(8'h12, 8'h34, 8'h56);
    tick();
    tick();
    strobe(8'h12, 8'h34, 8'h57);
    tick();
    strobe(8'h12, 8'h34, 8'h58);
    wait_idle(200, 1'b0);

    // Invalid BCD nibbles and odd seconds.
    push_line({8'h31, 8'h3F, COL_ODD, 8'h33, 8'h34, COL_ODD, 8'h35, 8'h37});
    strobe(8'h1A, 8'h34, 8'h57);
    wait_idle(200, 1'b0);
    push_line(64'h3F30_3A30_393A_3030);
    strobe(8'hB0, 8'h09, 8'h00);
    wait_idle(200, 1'b0);

    // Reset while TEXT idx 4 is stalled.
    exp_q.push_back(9'h080);
    exp_q.push_back(9'h131);
    exp_q.push_back(9'h132);
    exp_q.push_back(9'h13A);
    exp_q.push_back(9'h133);
    strobe(8'h12, 8'h34, 8'h56);
    for (int i = 0; i < 5; i++) tick();
    out_ready = 1'b0;
    chk("idx4_data", {24'd0, out_data}, 32'h34);
    chk("idx4_rs", {31'd0, out_rs}, 32'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd1);
    chk("rst_mid_drained", exp_q.size(), 32'd0);

    push_init();
    out_ready = 1'b1;
    rst = 1'b1;
    cnt = 0;
    while (!out_valid && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("pwr_wait_rerun", cnt, INIT_W);
    wait_idle(300, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_clock_formatter.md
Name: lcd_clock_formatter

Overview:
- Upstream feeder for the LCD byte-writer stage, which drives RS/E/RW/DB.
- Runs the HD44780 power-on init sequence, then converts BCD time snapshots into the line-1 text "HH:MM:SS".
- Emits that text as a stream of {RS, byte} transfers over a valid/ready handshake.
- The writer owns E-pulse timing; this block owns content and ordering.

Parameters:
- INIT_WAIT_CYCLES, 600000: idle cycles after reset before the first command (30 ms at 20 MHz).
- CLEAR_WAIT_CYCLES, 40000: wait after the Clear Display transfer is accepted (2 ms at 20 MHz).
- LINE1_ADDR, 8'h80: Set-DDRAM-address command issued before each text refresh.

Ports:
- clk, in, 1: system clock; single clock domain.
- rst, in, 1: synchronous, active-low reset (0 = reset), sampled on posedge clk.
- time_valid, in, 1: one-cycle strobe; a new time snapshot is present.
- hh_bcd, in, 8: hours, two BCD digits.
- mm_bcd, in, 8: minutes, two BCD digits.
- ss_bcd, in, 8: seconds, two BCD digits.
- out_valid, out, 1: transfer offered to the writer.
- out_ready, in, 1: writer accepts the transfer this cycle.
- out_rs, out, 1: 0 = command, 1 = character data.
- out_data, out, 8: command or ASCII byte.
- busy, out, 1: high in every state except IDLE.

Behaviour:
- Reset (rst=0 at posedge): state=PWR_WAIT; wait counter=0; out_valid=0, out_rs=0, out_data=0, busy=1; snapshot regs=0, pending=0.
  - Reset mid-transfer drops the offered byte immediately; no handshake completes.
- Transfer rule: a transfer completes when out_valid && out_ready at posedge.
  - While out_valid=1 and out_ready=0, out_rs and out_data are held stable.
  - out_valid never drops without a completed transfer, except on reset.
  - The next byte may be offered on the cycle after a completion (back-to-back, max 1 transfer/cycle).
- States:
  - PWR_WAIT: count to INIT_WAIT_CYCLES-1, then go to INIT.
  - INIT: offer 0x38, 0x0C, 0x06, 0x01 in order, each RS=0. The index advances on each completion. After 0x01 completes, go to CLR_WAIT.
  - CLR_WAIT: count CLEAR_WAIT_CYCLES, then go to IDLE, or to ADDR if pending=1.
  - IDLE: out_valid=0. On time_valid, latch hh/mm/ss and go to ADDR.
  - ADDR: offer LINE1_ADDR with RS=0. On completion, go to TEXT with char index=0.
  - TEXT: offer char[idx] with RS=1, idx 0..7. After idx 7 completes: if pending=1, clear pending, copy the pending snapshot into the working snapshot, and go to ADDR; otherwise go to IDLE.
- Character map:
  - idx 0/1 = hh tens/units, 3/4 = mm, 6/7 = ss; idx 2 and 5 = ':' (0x3A).
  - Digit n (0-9) maps to 0x30+n. A BCD nibble above 9 maps to '?' (0x3F).
- Snapshot handling:
  - time_valid while busy (any non-IDLE state) stores the values in a pending snapshot and sets pending=1.
  - A later strobe overwrites the pending snapshot (latest wins).
  - The working snapshot never changes mid-line.
- Simultaneous events: time_valid in the same cycle as the final TEXT completion lands in pending, so a refresh follows.
- Latency: strobe in IDLE gives out_valid=1 for ADDR on the next cycle. A full line is at least 9 transfers.
- Counters are sized by $clog2 of their parameter; no wrap is possible because each counter stops at its terminal count.

Optional Feature:
- Macro: LCD_BLINK_COLON_EN.
- Defined: idx 2 and 5 emit ' ' (0x20) when the working snapshot's ss units digit is odd, and ':' when it is even.
- Undefined: colons are always 0x3A. Port list is identical in both builds.

Decomposition:
- Package lcd_pkg holds:
  - command constants LCD_FUNC_SET=8'h38, LCD_DISP_ON=8'h0C, LCD_ENTRY=8'h06, LCD_CLEAR=8'h01;
  - ASCII constants for '0', ':', ' ', '?';
  - the state enum {PWR_WAIT, INIT, CLR_WAIT, IDLE, ADDR, TEXT}.
- Sub-module bcd_digit_ascii: combinational, 4-bit BCD in, 8-bit ASCII out, with the '?' rule. Instantiated once, fed by a mux on idx.

Test Plan:
- Reset then out_ready=1: out_valid stays 0 for exactly INIT_WAIT_CYCLES cycles, then RS=0 bytes 38,0C,06,01 appear; the next offer comes no earlier than CLEAR_WAIT_CYCLES after the 01 completion.
- After init, strobe hh=8'h12, mm=8'h34, ss=8'h56: 80 (RS=0), then RS=1 bytes 31 32 3A 33 34 3A 35 36; busy drops after the last byte.
- Randomized out_ready stall (hold low 0-5 cycles): out_data/out_rs stable during every stall; byte sequence identical to the previous case.
- Strobe 12:34:56, then mid-line strobe 12:34:57 and 12:34:58: current line completes unchanged, then exactly one more line "12:34:58"; 12:34:57 is never emitted.
- hh=8'h1A: idx 1 emits 0x3F. With LCD_BLINK_COLON_EN and ss=8'h57: idx 2 and 5 emit 0x20.
- rst=0 asserted during TEXT idx 4 with out_ready=0: next cycle out_valid=0 and state=PWR_WAIT; after release, the full init sequence reruns.
